gate_function_identifier: RTL and testbench

- Sequential probe that sits on the other side of the 3-bit-select, 2-input gate selector (the NAND-built function unit).
- The selector turns sel into a logic function; this block does the reverse: it drives all four (a,b) combinations into a selector instance, samples its output and rebuilds the 4-entry truth table.
- It then decodes the truth table back to the sel code.
- Used by the lab self-check harness, and on board to identify which function a sel setting produces.

---
 rtl/gate_function_identifier.sv | 148 ++++++++++++++
 tb/tb_gate_function_identifier.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_function_identifier.sv
// Probes a 2-input gate selector with all four {a,b} inputs and records the
// output as a truth table.
// The truth table is then decoded back to the selector's sel code.
// Ports: clk, rst (sync, active high), start -> a, b stimulus; dut_out sample;
// busy, done, tt[3:0], sel_id[2:0], valid_id, err results.
module gate_function_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic [2:0] sel_id,
  output logic       valid_id,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] sel_q, sel_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Table as it will look once the current sample lands.
  logic [3:0] tt_smp;
  logic [2:0] dec_sel;
  logic       dec_vld;

  always_comb begin
    tt_smp = tt_q;
    tt_smp[idx_q] = dut_out;
  end

  always_comb begin
    dec_sel = 3'b000;
    dec_vld = 1'b1;
    case (tt_smp)
      4'b0111: dec_sel = 3'b000;
      4'b1000: dec_sel = 3'b001;
      4'b1110: dec_sel = 3'b010;
      4'b0001: dec_sel = 3'b011;
      4'b0110: dec_sel = 3'b100;
      4'b1001: dec_sel = 3'b101;
      // sel 110 and 111 both give NOT a; 110 is reported.
      4'b0011: dec_sel = 3'b110;
      default: dec_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PROBE;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      PROBE: begin
        if (cnt_q == LAST) begin
          tt_d  = tt_smp;
          cnt_d = 4'd0;
          // Wraps to 0 after the last step, parking a/b at 00.
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sel_d   = dec_sel;
            vld_d   = dec_vld;
            err_d   = ~dec_vld;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 4'b0000;
      sel_q   <= 3'b000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // idx is 0 outside PROBE, so a/b come straight from a register.
  assign a        = idx_q[1];
  assign b        = idx_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt       = tt_q;
  assign sel_id   = sel_q;
  assign valid_id = vld_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gate_function_identifier.sv
// Scoreboard bench for gate_function_identifier.
// A NAND-built selector model sits on the probe's a/b/out.
module tb_gate_function_identifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0;
  logic       start1 = 1'b0;
  logic [2:0] sel = 3'b000;
  logic       stuck = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       a2, b2, out2, busy2, done2, v2, e2;
  logic [3:0] tt2;
  logic [2:0] sid2;
  logic       a1, b1, out1, busy1, done1, v1, e1;
  logic [3:0] tt1;
  logic [2:0] sid1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic nd(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic sel_fn(input logic [2:0] s,
                                  input logic x, input logic y);
    logic t;
    t = nd(x, y);
    case (s)
      3'd0:    return t;
      3'd1:    return nd(t, t);
      3'd2:    return nd(nd(x, x), nd(y, y));
      3'd3:    return ~nd(nd(x, x), nd(y, y));
      3'd4:    return nd(nd(x, t), nd(y, t));
      3'd5:    return ~nd(nd(x, t), nd(y, t));
      default: return nd(x, x);
    endcase
  endfunction

  assign out2 = stuck ? 1'b1 : sel_fn(sel, a2, b2);
  assign out1 = sel_fn(3'b100, a1, b1);

  gate_function_identifier #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .dut_out(out2),
    .busy(busy2), .done(done2), .tt(tt2),
    .sel_id(sid2), .valid_id(v2), .err(e2)
  );

  gate_function_identifier #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .dut_out(out1),
    .busy(busy1), .done(done1), .tt(tt1),
    .sel_id(sid1), .valid_id(v1), .err(e1)
  );

  typedef struct {
    logic [3:0] tt;
    logic [2:0] sel;
    logic       v;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done2_unexpected: got done=1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e = q2.pop_front();
        chk("done2_cycle", cyc, e.cyc);
        chk("tt2", int'(tt2), int'(e.tt));
        chk("sel_id2", int'(sid2), int'(e.sel));
        chk("valid_id2", int'(v2), int'(e.v));
        chk("err2", int'(e2), int'(e.e));
        chk("busy2_at_done", int'(busy2), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done1_unexpected: got done=1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.cyc);
        chk("tt1", int'(tt1), int'(e.tt));
        chk("sel_id1", int'(sid1), int'(e.sel));
        chk("valid_id1", int'(v1), int'(e.v));
        chk("err1", int'(e1), int'(e.e));
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] t, input logic [2:0] s,
                              input logic v, input logic e, input int c);
    exp_t x;
    x.tt = t;
    x.sel = s;
    x.v = v;
    x.e = e;
    x.cyc = c;
    return x;
  endfunction

  task automatic wait_q2(input int lim);
    int n = 0;
    while (q2.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL timeout2: got %0d pending expected 0", q2.size());
      q2.delete();
    end
  endtask

  task automatic run2(input logic [2:0] s, input logic [3:0] t,
                      input logic [2:0] es, input logic v, input logic e);
    sel = s;
    @(negedge clk);
    q2.push_back(mk(t, es, v, e, cyc + 9));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_q2(40);
  endtask

  logic [3:0] tt_tab [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                             4'b0110, 4'b1001, 4'b0011, 4'b0011};
  logic [2:0] id_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd3,
                             3'd4, 3'd5, 3'd6, 3'd6};

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_ab", int'({a2, b2}), 0);
    chk("rst_tt", int'(tt2), 0);
    chk("rst_sel_id", int'(sid2), 0);
    chk("rst_valid_err", int'({v2, e2}), 0);
    rst = 1'b0;

    // First run with an a/b and busy trace.
    sel = 3'd0;
    @(negedge clk);
    n = cyc;
    q2.push_back(mk(tt_tab[0], id_tab[0], 1'b1, 1'b0, n + 9));
    start2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      chk($sformatf("ab_trace_c%0d", k), int'({a2, b2}),
          (k <= 8) ? (k - 1) / 2 : 0);
      chk($sformatf("busy_trace_c%0d", k), int'(busy2),
          (k <= 8) ? 1 : 0);
    end
    wait_q2(40);

    for (int s = 1; s < 8; s++)
      run2(3'(s), tt_tab[s], id_tab[s], 1'b1, 1'b0);

    // Stuck-at-1 selector.
    stuck = 1'b1;
    run2(3'd0, 4'b1111, 3'd0, 1'b0, 1'b1);
    stuck = 1'b0;

    // Start held high for 20 cycles.
    sel = 3'd1;
    @(negedge clk);
    n = cyc;
    q2.push_back(mk(4'b1000, 3'd1, 1'b1, 1'b0, n + 9));
    q2.push_back(mk(4'b1000, 3'd1, 1'b1, 1'b0, n + 19));
    start2 = 1'b1;
    repeat (20) @(negedge clk);
    start2 = 1'b0;
    wait_q2(40);
    repeat (12) @(negedge clk);

    // Reset in cycle 4 of a run.
    sel = 3'd1;
    @(negedge clk);
    q2.push_back(mk(4'b1000, 3'd1, 1'b1, 1'b0, cyc + 9));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", int'(busy2), 1);
    q2.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy2), 0);
    chk("rst_mid_ab", int'({a2, b2}), 0);
    chk("rst_mid_tt", int'(tt2), 0);
    chk("rst_mid_sel_id", int'(sid2), 0);
    chk("rst_mid_valid_err", int'({v2, e2}), 0);
    chk("rst_mid_done", int'(done2), 0);
    repeat (14) @(negedge clk);
    run2(3'd1, 4'b1000, 3'd1, 1'b1, 1'b0);

    // SETTLE_CYCLES=1 instance, selector fixed at XOR.
    @(negedge clk);
    n = cyc;
    q1.push_back(mk(4'b0110, 3'd4, 1'b1, 1'b0, n + 5));
    start1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      chk($sformatf("busy1_c%0d", k), int'(busy1), (k <= 4) ? 1 : 0);
    end
    n = 0;
    while (q1.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL timeout1: got %0d pending expected 0", q1.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
